// File: rtl/serial_arith_pkg.sv
// Shared definitions for the digit-serial arithmetic blocks: FSM encodings,
// add/subtract mode constants and a width helper for counters.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Bits needed to count 0..value-1; never less than one so a
   // single-digit configuration still gets a real counter.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/digit_full_adder.sv
// DIGIT-wide ripple-carry adder used as the per-cycle arithmetic slice.
module digit_full_adder #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co
);

   logic [DIGIT:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < DIGIT; i++) begin : g_bit
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign co = c[DIGIT];

endmodule

// File: rtl/serial_addsub.sv
// Handshaked digit-serial adder/subtractor: latches operands on start,
// processes DIGIT bits per cycle LSB first, streams digits and reports on done.
module serial_addsub
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic [DIGIT-1:0] s_ser,
   output logic             s_ser_vld,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int K  = WIDTH / DIGIT;
   localparam int CW = clog2(K);
   localparam logic [CW-1:0] LAST = CW'(K - 1);

   state_t state, state_next;

   logic [WIDTH-1:0]       a_q, b_q, res_q, sum_q;
   logic                   carry_q, cout_q, ovf_q;
   logic                   a_msb_q, b_msb_q;
   logic [CW-1:0]          cnt_q;
   logic [DIGIT-1:0]       dsum;
   logic                   dco;
   logic                   accept, last;
   logic [WIDTH+DIGIT-1:0] res_cat;
   logic [WIDTH-1:0]       res_next;

   digit_full_adder #(.DIGIT(DIGIT)) u_fa (
      .a  (a_q[DIGIT-1:0]),
      .b  (b_q[DIGIT-1:0]),
      .ci (carry_q),
      .s  (dsum),
      .co (dco)
   );

   assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign last   = (state == ST_RUN) && (cnt_q == LAST);

   // New digit enters at the top; after K shifts the first digit sits at bit 0.
   assign res_cat  = {dsum, res_q};
   assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start) state_next = ST_RUN;
         ST_RUN:  if (cnt_q == LAST) state_next = ST_DONE;
         ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         cnt_q   <= '0;
      end else if (accept) begin
         // Subtraction is a + ~b + ~borrow, so cout reads as "no borrow".
         a_q     <= a;
         b_q     <= (sub == MODE_SUB) ? ~b : b;
         carry_q <= (sub == MODE_SUB) ? ~cin : cin;
         a_msb_q <= a[WIDTH-1];
         b_msb_q <= (sub == MODE_SUB) ? ~b[WIDTH-1] : b[WIDTH-1];
         res_q   <= '0;
         cnt_q   <= '0;
      end else if (state == ST_RUN) begin
         carry_q <= dco;
         res_q   <= res_next;
         a_q     <= a_q >> DIGIT;
         b_q     <= b_q >> DIGIT;
         cnt_q   <= cnt_q + 1'b1;
         if (last) begin
            sum_q  <= res_next;
            cout_q <= dco;
            ovf_q  <= (a_msb_q == b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
         end
      end
   end

   assign busy      = (state == ST_RUN);
   assign s_ser_vld = (state == ST_RUN);
   assign s_ser     = (state == ST_RUN) ? dsum : '0;
   assign done      = (state == ST_DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub across four width/digit configurations.
module tb_serial_addsub;

   logic       clk = 1'b0;
   logic       reset;
   logic       sub;
   logic       cin;
   logic [3:0] start_v;
   logic [7:0] a_in, b_in;
   int         sel;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   logic       d4_busy, d4_vld, d4_done, d4_cout, d4_ovf, d4_ser;
   logic [3:0] d4_sum;
   logic       d8_busy, d8_vld, d8_done, d8_cout, d8_ovf, d8_ser;
   logic [7:0] d8_sum;
   logic       dq_busy, dq_vld, dq_done, dq_cout, dq_ovf;
   logic [3:0] dq_ser;
   logic [7:0] dq_sum;
   logic       d5_busy, d5_vld, d5_done, d5_cout, d5_ovf, d5_ser;
   logic [4:0] d5_sum;

   serial_addsub #(.WIDTH(4), .DIGIT(1)) dut4 (
      .clk(clk), .reset(reset), .start(start_v[0]), .sub(sub),
      .a(a_in[3:0]), .b(b_in[3:0]), .cin(cin),
      .busy(d4_busy), .s_ser(d4_ser), .s_ser_vld(d4_vld), .done(d4_done),
      .sum(d4_sum), .cout(d4_cout), .ovf(d4_ovf));

   serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (
      .clk(clk), .reset(reset), .start(start_v[1]), .sub(sub),
      .a(a_in), .b(b_in), .cin(cin),
      .busy(d8_busy), .s_ser(d8_ser), .s_ser_vld(d8_vld), .done(d8_done),
      .sum(d8_sum), .cout(d8_cout), .ovf(d8_ovf));

   serial_addsub #(.WIDTH(8), .DIGIT(4)) dut84 (
      .clk(clk), .reset(reset), .start(start_v[2]), .sub(sub),
      .a(a_in), .b(b_in), .cin(cin),
      .busy(dq_busy), .s_ser(dq_ser), .s_ser_vld(dq_vld), .done(dq_done),
      .sum(dq_sum), .cout(dq_cout), .ovf(dq_ovf));

   serial_addsub #(.WIDTH(5), .DIGIT(1)) dut5 (
      .clk(clk), .reset(reset), .start(start_v[3]), .sub(sub),
      .a(a_in[4:0]), .b(b_in[4:0]), .cin(cin),
      .busy(d5_busy), .s_ser(d5_ser), .s_ser_vld(d5_vld), .done(d5_done),
      .sum(d5_sum), .cout(d5_cout), .ovf(d5_ovf));

   logic       o_busy, o_vld, o_done, o_cout, o_ovf;
   logic [7:0] o_ser, o_sum;

   always_comb begin
      o_busy = d8_busy; o_vld = d8_vld; o_done = d8_done;
      o_cout = d8_cout; o_ovf = d8_ovf;
      o_ser  = {7'b0, d8_ser};
      o_sum  = d8_sum;
      case (sel)
         0: begin
            o_busy = d4_busy; o_vld = d4_vld; o_done = d4_done;
            o_cout = d4_cout; o_ovf = d4_ovf;
            o_ser  = {7'b0, d4_ser}; o_sum = {4'b0, d4_sum};
         end
         2: begin
            o_busy = dq_busy; o_vld = dq_vld; o_done = dq_done;
            o_cout = dq_cout; o_ovf = dq_ovf;
            o_ser  = {4'b0, dq_ser}; o_sum = dq_sum;
         end
         3: begin
            o_busy = d5_busy; o_vld = d5_vld; o_done = d5_done;
            o_cout = d5_cout; o_ovf = d5_ovf;
            o_ser  = {7'b0, d5_ser}; o_sum = {3'b0, d5_sum};
         end
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input int which, input logic s, input logic [7:0] a,
                         input logic [7:0] b, input logic c);
      sel  = which;
      sub  = s;
      a_in = a;
      b_in = b;
      cin  = c;
      start_v[which] = 1'b1;
      @(posedge clk); #1;
      start_v = '0;
   endtask

   // Walks the K RUN cycles from cycle 0 and ends sampling the DONE cycle.
   task automatic check_run(input int k, input int d, input logic [7:0] es,
                            input logic ec, input logic eo, input bit glitch);
      logic [7:0] dig;
      for (int n = 0; n < k; n++) begin
         dig = (es >> (n * d)) & 8'((1 << d) - 1);
         check("run_busy", 32'(o_busy), 32'd1);
         check("run_vld", 32'(o_vld), 32'd1);
         check("run_done_early", 32'(o_done), 32'd0);
         check("s_ser", 32'(o_ser), 32'(dig));
         if (glitch && n == 1) begin
            a_in = 8'h0F; b_in = 8'h0F; sub = 1'b1; cin = 1'b1;
            start_v[sel] = 1'b1;
         end
         @(posedge clk); #1;
         start_v = '0;
      end
      check("done", 32'(o_done), 32'd1);
      check("done_busy", 32'(o_busy), 32'd0);
      check("done_vld", 32'(o_vld), 32'd0);
      check("done_ser", 32'(o_ser), 32'd0);
      check("sum", 32'(o_sum), 32'(es));
      check("cout", 32'(o_cout), 32'(ec));
      check("ovf", 32'(o_ovf), 32'(eo));
   endtask

   task automatic idle_check(input logic [7:0] es);
      @(posedge clk); #1;
      check("idle_done", 32'(o_done), 32'd0);
      check("idle_busy", 32'(o_busy), 32'd0);
      check("idle_sum_held", 32'(o_sum), 32'(es));
   endtask

   initial begin
      reset = 1'b1; sub = 1'b0; cin = 1'b0;
      a_in = '0; b_in = '0; start_v = '0; sel = 1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_vld", 32'(o_vld), 32'd0);
      check("rst_ser", 32'(o_ser), 32'd0);
      check("rst_sum", 32'(o_sum), 32'd0);
      check("rst_cout", 32'(o_cout), 32'd0);
      check("rst_ovf", 32'(o_ovf), 32'd0);
      reset = 1'b0;

      // 4-bit: 1111 + 1101 + 1 = 1_1101
      launch(0, 1'b0, 8'h0F, 8'h0D, 1'b1);
      check_run(4, 1, 8'h0D, 1'b1, 1'b0, 1'b0);
      idle_check(8'h0D);

      // 8-bit subtraction with and without borrow
      launch(1, 1'b1, 8'h05, 8'h03, 1'b0);
      check_run(8, 1, 8'h02, 1'b1, 1'b0, 1'b0);
      idle_check(8'h02);
      launch(1, 1'b1, 8'h03, 8'h05, 1'b0);
      check_run(8, 1, 8'hFE, 1'b0, 1'b0, 1'b0);
      idle_check(8'hFE);

      // Signed overflow in both modes
      launch(1, 1'b0, 8'h7F, 8'h01, 1'b0);
      check_run(8, 1, 8'h80, 1'b0, 1'b1, 1'b0);
      idle_check(8'h80);
      launch(1, 1'b1, 8'h80, 8'h01, 1'b0);
      check_run(8, 1, 8'h7F, 1'b1, 1'b1, 1'b0);
      idle_check(8'h7F);

      // Nibble digits: carry must cross the digit boundary
      launch(2, 1'b0, 8'hFF, 8'h01, 1'b0);
      check_run(2, 4, 8'h00, 1'b1, 1'b0, 1'b0);
      idle_check(8'h00);

      // 5-bit: start during RUN ignored, then back-to-back start from DONE
      launch(3, 1'b0, 8'h1B, 8'h11, 1'b0);
      check_run(5, 1, 8'h0C, 1'b1, 1'b1, 1'b1);
      launch(3, 1'b0, 8'h03, 8'h04, 1'b0);
      check_run(5, 1, 8'h07, 1'b0, 1'b0, 1'b0);
      idle_check(8'h07);

      // Reset in RUN cycle 2 abandons the operation
      launch(1, 1'b0, 8'h55, 8'h0F, 1'b0);
      repeat (2) begin
         @(posedge clk); #1;
      end
      check("mid_busy", 32'(o_busy), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_busy", 32'(o_busy), 32'd0);
      check("abort_done", 32'(o_done), 32'd0);
      check("abort_vld", 32'(o_vld), 32'd0);
      check("abort_ser", 32'(o_ser), 32'd0);
      check("abort_sum", 32'(o_sum), 32'd0);
      check("abort_cout", 32'(o_cout), 32'd0);
      check("abort_ovf", 32'(o_ovf), 32'd0);
      idle_check(8'h00);
      launch(1, 1'b0, 8'h10, 8'h20, 1'b0);
      check_run(8, 1, 8'h30, 1'b0, 1'b0, 1'b0);
      idle_check(8'h30);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, handshaked, digit-serial adder/subtractor; next generation of the team's 1-bit serial adder.
- Latches two WIDTH-bit operands on start and processes DIGIT bits per clock, LSB digit first, through a registered carry.
- Streams each result digit as it is produced and presents a parallel sum with carry/borrow and signed-overflow flags on done.
- Sits between a parallel register interface and any bit/digit-serial consumer in the datapath.

Parameters:
- WIDTH, 8: operand/result width in bits; must be >= 2 and a multiple of DIGIT.
- DIGIT, 1: bits processed per cycle; K = WIDTH/DIGIT RUN cycles per operation.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = add, 1 = subtract; latched on accepted start.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- cin  input  1  carry-in (add) or borrow-in (sub); latched on accepted start.
- busy  output  1  high while in RUN.
- s_ser  output  DIGIT  current result digit.
- s_ser_vld  output  1  s_ser valid; high for exactly K consecutive cycles per operation.
- done  output  1  one-cycle pulse; parallel results valid.
- sum  output  WIDTH  parallel result; held until the next accepted start.
- cout  output  1  add: carry-out. Sub: 1 = no borrow (a >= b + cin).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it is sampled on the clk rising edge and overrides everything else.
- Reset values: state = IDLE, busy = 0, done = 0, s_ser_vld = 0, s_ser = 0, sum = 0, cout = 0, ovf = 0, digit count = 0, carry register = 0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start = 1. DONE -> RUN on start = 1. DONE -> IDLE otherwise. RUN -> DONE after digit K-1.
- Accepted start (edge E0): load shift registers with a and b' (b' = b when sub = 0, ~b when sub = 1). Load carry register with cin (add) or ~cin (sub). Clear count.
- RUN cycle n (n = 0..K-1):
  - Digit adder computes A[n] + B'[n] + carry.
  - s_ser = that digit sum, combinationally from registered state; s_ser_vld = 1; busy = 1.
  - On the edge: carry register takes the digit carry-out, the digit shifts into the result register, and the operand registers shift right by DIGIT.
- After edge E0 + K: state = DONE, done = 1 for exactly one cycle. sum, cout and ovf update on that same edge.
- Latency: done is high in the cycle following edge E0 + K. Back-to-back start from DONE gives a throughput of one operation per K+1 cycles.
- ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), using the latched operands.
- start while in RUN: ignored. Latched operands and mode are unaffected. Input changes during RUN have no effect.
- reset during RUN: operation abandoned, reset values applied. No done pulse; the next start begins fresh.
- s_ser = 0 and s_ser_vld = 0 outside RUN.
- Arithmetic is modulo 2^WIDTH. Carry is never lost between digits.

Decomposition:
- Shared package serial_arith_pkg holds: state encodings (IDLE/RUN/DONE), the sub/add mode constants, and a clog2 function for the count width.
- One combinational sub-module, digit_full_adder (DIGIT-wide ripple adder: a, b, ci -> s, co), instantiated once.
- FSM, shift registers and flags live in serial_addsub.

Test Plan:
1. WIDTH=4, DIGIT=1, add, a=4'b1111, b=4'b1101, cin=1 -> s_ser sequence 1,0,1,1 over 4 cycles; done after E0+4; sum=4'b1101, cout=1 (11101), ovf=0.
2. WIDTH=8, DIGIT=1, sub: a=0x05, b=0x03, cin=0 -> sum=0x02, cout=1. Then a=0x03, b=0x05 -> sum=0xFE, cout=0, ovf=0.
3. WIDTH=8, DIGIT=1, add: 0x7F + 0x01 -> sum=0x80, cout=0, ovf=1. Sub: 0x80 - 0x01 -> sum=0x7F, cout=1, ovf=1.
4. WIDTH=8, DIGIT=4, add: 0xFF + 0x01, cin=0 -> s_ser 0x0 then 0x0; s_ser_vld high exactly 2 cycles; done after E0+2; sum=0x00, cout=1.
5. WIDTH=5, DIGIT=1, add: 5'b11011 + 5'b10001 -> sum=5'b01100, cout=1. During RUN, pulse start with different operands -> ignored, same result. Then start in the done cycle -> new op accepted with no IDLE gap.
6. Assert reset for one cycle at RUN cycle 2 -> all outputs 0 next cycle, no done pulse. A subsequent 0x10 + 0x20 -> sum=0x30, cout=0.
